// File: rtl/lsu.sv
// Load/store unit for the RV32I core: lane steering, byte enables and load
// extension around a req/gnt/rvalid data-bus handshake.
module lsu #(
    parameter int DW  = 32,
    parameter int BEW = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           req_i,
    input  logic           we_i,
    input  logic [2:0]     func3_i,
    input  logic [DW-1:0]  addr_i,
    input  logic [DW-1:0]  wdata_i,
    output logic           stall_o,
    output logic [DW-1:0]  rdata_o,
    output logic           done_o,
    output logic           err_o,
    output logic           dbus_req_o,
    output logic           dbus_we_o,
    output logic [DW-1:0]  dbus_addr_o,
    output logic [BEW-1:0] dbus_be_o,
    output logic [DW-1:0]  dbus_wdata_o,
    input  logic           dbus_gnt_i,
    input  logic           dbus_rvalid_i,
    input  logic [DW-1:0]  dbus_rdata_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]     state_q;
    logic [DW-1:2]  word_q;
    logic [1:0]     off_q;
    logic [BEW-1:0] be_q;
    logic [DW-1:0]  wdata_q;
    logic           we_q;
    logic [2:0]     func3_q;
    logic [DW-1:0]  rdata_q;

    logic [1:0]     off;
    logic [BEW-1:0] be_n;
    logic [DW-1:0]  wdata_n;
    logic           legal;
    logic [DW-1:0]  shifted;
    logic [DW-1:0]  ext;

    assign off = addr_i[1:0];

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        be_n    = '0;
        wdata_n = wdata_i;
        legal   = 1'b0;
        case (func3_i[1:0])
            2'b00: begin
                be_n    = 4'b0001 << off;
                wdata_n = {4{wdata_i[7:0]}};
                legal   = 1'b1;
            end
            2'b01: begin
                be_n    = 4'b0011 << off;
                wdata_n = {2{wdata_i[15:0]}};
                legal   = ~off[0];
            end
            2'b10: begin
                be_n  = 4'b1111;
                legal = (off == 2'b00);
            end
            default: legal = 1'b0;
        endcase
        // Stores only have sizes 000..010; loads have no 11x encodings.
        if (func3_i[2] && (we_i || func3_i[1]))
            legal = 1'b0;
    end

    assign shifted = dbus_rdata_i >> {off_q, 3'b000};

    always_comb begin
        ext = dbus_rdata_i;
        case (func3_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ext = {24'b0, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ext = {16'b0, shifted[15:0]};
            default: ext = dbus_rdata_i;
        endcase
    end

    // Gated by rst_i so every output reads 0 while reset is held, even with req_i high.
    assign err_o   = ~rst_i & req_i & (state_q == IDLE) & ~legal;
    assign stall_o = ~rst_i & req_i & ~err_o & (state_q != DONE);
    assign done_o  = (state_q == DONE);
    assign dbus_req_o   = (state_q == REQ);
    assign dbus_we_o    = we_q;
    assign dbus_addr_o  = {word_q, 2'b00};
    assign dbus_be_o    = be_q;
    assign dbus_wdata_o = wdata_q;
    assign rdata_o      = rdata_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            word_q  <= '0;
            off_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            func3_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i && legal) begin
                        word_q  <= addr_i[DW-1:2];
                        off_q   <= off;
                        be_q    <= be_n;
                        wdata_q <= wdata_n;
                        we_q    <= we_i;
                        func3_q <= func3_i;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (dbus_gnt_i) begin
                        if (we_q) begin
                            state_q <= DONE;
                        end else if (dbus_rvalid_i) begin
                            rdata_q <= ext;
                            state_q <= DONE;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dbus_rvalid_i) begin
                        rdata_q <= ext;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized accesses
// compared against an arithmetic reference model of lanes, legality and extension.
module tb_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [2:0]  func3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        err_o;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_gnt_i;
    logic        dbus_rvalid_i;
    logic [31:0] dbus_rdata_i;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata = '0;

    lsu #(.DW(32), .BEW(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
        .func3_i(func3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit ref_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
        if (we && f3 > 3'd2) return 1'b0;
        if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b0;
        return (int'(a[1:0]) % size_bytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] off);
        int n = size_bytes(f3);
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (size_bytes(f3))
            1:       return {24'b0, wd[7:0]} * 32'h0101_0101;
            2:       return {16'b0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
        int          n = size_bytes(f3);
        logic [31:0] v;
        logic [31:0] mask;
        if (n == 4) return word;
        v    = word >> (8 * off);
        mask = (32'h1 << (8 * n)) - 32'h1;
        v    = v & mask;
        if (!f3[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            req_i = 1'b0; dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
            #1;
            check("idle_stall", stall_o, 0);
            check("idle_busreq", dbus_req_o, 0);
            check("idle_done", done_o, 0);
        end
    endtask

    // One access on the ideal schedule: gnt after gdly REQ cycles, rvalid rdly cycles after gnt.
    task automatic run_access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input int gdly, input int rdly,
                              input logic [31:0] word, input bit abort);
        bit legal = ref_legal(we, f3, addr);
        tick();
        req_i = 1'b1; we_i = we; func3_i = f3; addr_i = addr; wdata_i = wd;
        dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
        #1;
        if (!legal) begin
            check("ill_err", err_o, 1);
            check("ill_stall", stall_o, 0);
            check("ill_busreq", dbus_req_o, 0);
            tick();
            req_i = 1'b0;
            #1;
            check("ill_busreq_next", dbus_req_o, 0);
            check("ill_err_next", err_o, 0);
            check("ill_done_next", done_o, 0);
            return;
        end
        check("c0_err", err_o, 0);
        check("c0_stall", stall_o, 1);
        check("c0_busreq", dbus_req_o, 0);
        for (int k = 0; k <= gdly; k++) begin
            tick();
            addr_i = $urandom; func3_i = 3'($urandom); wdata_i = $urandom;
            dbus_gnt_i = (k == gdly);
            dbus_rvalid_i = (k == gdly) && !we && (rdly == 0);
            dbus_rdata_i = dbus_rvalid_i ? word : $urandom;
            #1;
            check("req_busreq", dbus_req_o, 1);
            check("req_addr", dbus_addr_o, {addr[31:2], 2'b00});
            check("req_be", dbus_be_o, ref_be(f3, addr[1:0]));
            check("req_we", dbus_we_o, we);
            if (we) check("req_wdata", dbus_wdata_o, ref_wdata(f3, wd));
            check("req_stall", stall_o, 1);
            check("req_done", done_o, 0);
        end
        if (!we) begin
            for (int k = 1; k <= rdly; k++) begin
                tick();
                dbus_gnt_i = 1'b0;
                dbus_rvalid_i = (k == rdly);
                dbus_rdata_i = dbus_rvalid_i ? word : $urandom;
                #1;
                check("wait_busreq", dbus_req_o, 0);
                check("wait_stall", stall_o, 1);
                check("wait_done", done_o, 0);
                if (abort) begin
                    dbus_rvalid_i = 1'b0;
                    #1;
                    rst_i = 1'b1;
                    #1;
                    check("rst_busreq", dbus_req_o, 0);
                    check("rst_stall", stall_o, 0);
                    check("rst_done", done_o, 0);
                    check("rst_be", dbus_be_o, 0);
                    tick();
                    tick();
                    rst_i = 1'b0; req_i = 1'b0;
                    last_rdata = '0;
                    #1;
                    check("rst_rdata", rdata_o, last_rdata);
                    check("rst_idle_busreq", dbus_req_o, 0);
                    return;
                end
            end
        end
        tick();
        dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = $urandom;
        #1;
        check("done_pulse", done_o, 1);
        check("done_stall", stall_o, 0);
        check("done_busreq", dbus_req_o, 0);
        check("done_err", err_o, 0);
        if (!we) last_rdata = ref_load(f3, addr[1:0], word);
        check("done_rdata", rdata_o, last_rdata);
    endtask

    initial begin
        rst_i = 1'b1; req_i = 1'b1; we_i = 1'b1; func3_i = 3'd2; addr_i = 32'h104;
        wdata_i = 32'h1234_5678; dbus_gnt_i = 1'b1; dbus_rvalid_i = 1'b1; dbus_rdata_i = '1;
        #2;
        check("reset_stall", stall_o, 0);
        check("reset_err", err_o, 0);
        check("reset_done", done_o, 0);
        check("reset_busreq", dbus_req_o, 0);
        check("reset_we", dbus_we_o, 0);
        check("reset_addr", dbus_addr_o, 0);
        check("reset_be", dbus_be_o, 0);
        check("reset_wdata", dbus_wdata_o, 0);
        check("reset_rdata", rdata_o, 0);
        tick();
        rst_i = 1'b0; req_i = 1'b0; dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;

        run_access(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 32'h0, 1'b0);
        idle(1);
        run_access(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 3, 0, 32'h0, 1'b0);
        idle(1);
        run_access(1'b0, 3'b000, 32'h102, 32'h0, 0, 1, 32'h12F0_3456, 1'b0);
        check("lb_value", rdata_o, 32'hFFFF_FFF0);
        run_access(1'b0, 3'b100, 32'h102, 32'h0, 0, 1, 32'h12F0_3456, 1'b0);
        check("lbu_value", rdata_o, 32'h0000_00F0);
        idle(1);
        run_access(1'b0, 3'b001, 32'h101, 32'h0, 0, 0, 32'h0, 1'b0);
        run_access(1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h0, 1'b0);
        run_access(1'b0, 3'b110, 32'h100, 32'h0, 0, 0, 32'h0, 1'b0);
        run_access(1'b1, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0, 1'b0);
        idle(1);
        run_access(1'b0, 3'b010, 32'h200, 32'h0, 0, 3, 32'hCAFE_F00D, 1'b1);
        run_access(1'b0, 3'b010, 32'h0, 32'h0, 0, 0, 32'h5566_7788, 1'b0);
        idle(1);
        run_access(1'b1, 3'b010, 32'h104, 32'h0BAD_F00D, 0, 0, 32'h0, 1'b0);
        run_access(1'b0, 3'b101, 32'h106, 32'h0, 0, 1, 32'h8001_ABCD, 1'b0);
        check("lhu_value", rdata_o, 32'h0000_8001);

        for (int i = 0; i < 80; i++) begin
            run_access(1'($urandom), 3'($urandom), $urandom & 32'h3FF, $urandom,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom, 1'b0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
